// File: rtl/loss_batch_accum.sv
// loss_batch_accum
//   Batch-mean stage placed after the per-sample squared-error loss stage.
//   Accepts 2**BATCH_LOG2 unsigned losses over a valid/ready handshake. Sums
//   them in an accumulator that cannot overflow. Presents the truncated mean
//   over a second valid/ready handshake.
//
//   Optional feature macro: LOSS_BATCH_MAX_EN
//     When defined, adds output max_o. It carries the largest loss accepted
//     in the current batch.
//
//   Timing: the last sample is accepted at edge N. mean_o is loaded at N+1.
//   mean_valid_o rises at N+2. The consumer can complete the handshake at
//   N+3 at the earliest, which returns the FSM to IDLE.
module loss_batch_accum #(
  parameter int LOSS_W     = 46,
  parameter int BATCH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  loss_valid_i,
  input  logic [LOSS_W-1:0]     loss_i,
  output logic                  loss_ready_o,
  output logic                  mean_valid_o,
  output logic [LOSS_W-1:0]     mean_o,
  input  logic                  mean_ready_i,
`ifdef LOSS_BATCH_MAX_EN
  output logic [LOSS_W-1:0]     max_o,
`endif
  output logic                  busy_o,
  output logic [BATCH_LOG2:0]   count_o
);

  localparam int ACC_W = LOSS_W + BATCH_LOG2;
  localparam int CNT_W = BATCH_LOG2 + 1;

  // Count value held just before the final sample of a batch is accepted.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << BATCH_LOG2) - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DIV   = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  count_r;
  logic [LOSS_W-1:0] mean_r;
  logic              mean_valid_r;
  logic              loss_ready_r;
  logic              busy_r;

  logic              restart_s;
  logic              accept_s;
  logic              last_s;
  logic              handshake_s;
  logic              mean_valid_next_s;

  // Decode the handshake events seen by the current state.
  always_comb begin
    restart_s   = 1'b0;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE: begin
        restart_s = start_i;
      end
      ACCUM: begin
        // A start pulse wins over a sample presented in the same cycle.
        restart_s = start_i;
        accept_s  = loss_valid_i & loss_ready_r & ~start_i;
        last_s    = accept_s & (count_r == LAST_CNT);
      end
      OUT: begin
        handshake_s = mean_valid_r & mean_ready_i;
      end
      default: begin
        restart_s   = 1'b0;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        handshake_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for the IDLE/ACCUM/DIV/OUT sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (restart_s) begin
          state_next_s = ACCUM;
        end else if (last_s) begin
          state_next_s = DIV;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DIV: begin
        state_next_s = OUT;
      end
      OUT: begin
        if (handshake_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OUT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // mean_valid rises one edge after entering OUT, so mean_o is already stable.
  // It drops on the edge that completes the handshake.
  always_comb begin
    mean_valid_next_s = 1'b0;
    if (state_r == OUT) begin
      mean_valid_next_s = ~handshake_s;
    end else begin
      mean_valid_next_s = 1'b0;
    end
  end

  // State register plus the registered handshake and status outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      loss_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      mean_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      loss_ready_r <= (state_next_s == ACCUM);
      busy_r       <= (state_next_s != IDLE);
      mean_valid_r <= mean_valid_next_s;
    end
  end

  // Accumulator and sample counter. A start pulse clears them. Each accept advances them.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_r   <= '0;
      count_r <= '0;
    end else if (restart_s) begin
      acc_r   <= '0;
      count_r <= '0;
    end else if (accept_s) begin
      acc_r   <= acc_r + {{BATCH_LOG2{1'b0}}, loss_i};
      count_r <= count_r + CNT_W'(1);
    end else begin
      acc_r   <= acc_r;
      count_r <= count_r;
    end
  end

  // Load the truncated mean during DIV. Otherwise hold it until the next batch completes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mean_r <= '0;
    end else if (state_r == DIV) begin
      mean_r <= acc_r[ACC_W-1:BATCH_LOG2];
    end else begin
      mean_r <= mean_r;
    end
  end

`ifdef LOSS_BATCH_MAX_EN
  logic [LOSS_W-1:0] max_r;

  // Track the largest accepted loss of the current batch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      max_r <= '0;
    end else if (restart_s) begin
      max_r <= '0;
    end else if (accept_s && (loss_i > max_r)) begin
      max_r <= loss_i;
    end else begin
      max_r <= max_r;
    end
  end

  assign max_o = max_r;
`endif

  assign loss_ready_o = loss_ready_r;
  assign mean_valid_o = mean_valid_r;
  assign mean_o       = mean_r;
  assign busy_o       = busy_r;
  assign count_o      = count_r;

endmodule
